// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch, data-memory wait FSM with timeout.
// Optional performance counters are enabled with the PIPE_STALL_CNT_EN macro.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_memread,
  input  logic [4:0]           ex_rd,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 ifid_flush,
  output logic                 idex_stall,
  output logic                 idex_flush,
  output logic                 exmem_stall,
  output logic                 memwb_bubble,
  output logic                 mem_busy,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] lu_stall_cnt,
  output logic [CNT_WIDTH-1:0] mem_stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              mem_stall;
  logic              load_use;

  always_comb begin
    load_use = ex_memread && (ex_rd != '0) &&
               ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    mem_stall = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ack) begin
          mem_stall = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_d   = ERR;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Priority: memory wait freezes everything, then load-use bubble, then branch flush.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    mem_busy     = 1'b0;
    timeout_err  = 1'b0;
    if (!rst) begin
      mem_busy    = (state_q == MEM_WAIT);
      timeout_err = timeout_q;
      if (mem_stall) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end else if (branch_taken) begin
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] lu_cnt_q, mem_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      if (!mem_stall && load_use) lu_cnt_q <= lu_cnt_q + CNT_WIDTH'(1);
      if (mem_stall)              mem_cnt_q <= mem_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign lu_stall_cnt  = rst ? '0 : lu_cnt_q;
  assign mem_stall_cnt = rst ? '0 : mem_cnt_q;
`else
  assign lu_stall_cnt  = '0;
  assign mem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed memory/timeout sequences, randomized run vs. reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_uses_rt, ex_memread, branch_taken, mem_req, mem_ack;
  logic [4:0]    id_rs, id_rt, ex_rd;
  logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic          exmem_stall, memwb_bubble, mem_busy, timeout_err;
  logic [CW-1:0] lu_stall_cnt, mem_stall_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .memwb_bubble(memwb_bubble), .mem_busy(mem_busy),
    .timeout_err(timeout_err), .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       ack;
  } in_t;

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble, mem_busy, timeout_err}
  typedef logic [8:0] out_t;
  localparam out_t O_NONE = 9'b000000000;
  localparam out_t O_LU   = 9'b110010000;
  localparam out_t O_BR   = 9'b001000000;
  localparam out_t O_MS   = 9'b110101100;
  localparam out_t O_BUSY = 9'b000000010;
  localparam out_t O_TO   = 9'b000000001;

  typedef struct { in_t in; out_t exp; } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: stalled cycles of the current access, sticky error, counters.
  int          m_stalled = 0;
  bit          m_err = 1'b0;
  logic [CW-1:0] m_lu = '0, m_ms = '0;

  function automatic in_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic u, logic mr,
                             logic [4:0] rd, logic br, logic req, logic ack);
    in_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.uses_rt = u; v.memread = mr;
    v.rd = rd; v.br = br; v.req = req; v.ack = ack;
    return v;
  endfunction

  function automatic bit m_lu_hit(in_t v);
    return v.memread && v.rd != 0 && (v.rd == v.rs || (v.uses_rt && v.rd == v.rt));
  endfunction

  function automatic bit m_memstall(in_t v);
    return m_err || (!v.ack && (m_stalled > 0 || v.req));
  endfunction

  function automatic out_t model_out(in_t v);
    out_t o = O_NONE;
    if (v.rst) return O_NONE;
    if (m_memstall(v))   o = O_MS;
    else if (m_lu_hit(v)) o = O_LU;
    else if (v.br)        o = O_BR;
    if (!m_err && m_stalled > 0) o = o | O_BUSY;
    if (m_err) o = o | O_TO;
    return o;
  endfunction

  task automatic model_step(in_t v);
    bit ms;
    if (v.rst) begin
      m_stalled = 0; m_err = 1'b0; m_lu = '0; m_ms = '0;
    end else begin
      ms = m_memstall(v);
      if (ms) m_ms = m_ms + 1'b1;
      else if (m_lu_hit(v)) m_lu = m_lu + 1'b1;
      if (!m_err) begin
        if (ms) begin
          m_stalled++;
          if (m_stalled == int'(TO)) m_err = 1'b1;
        end else begin
          m_stalled = 0;
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic out_t dut_out();
    return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
            exmem_stall, memwb_bubble, mem_busy, timeout_err};
  endfunction

  function automatic logic [CW-1:0] exp_lu(logic r);
`ifdef PIPE_STALL_CNT_EN
    return r ? '0 : m_lu;
`else
    return r ? '0 : '0;
`endif
  endfunction

  function automatic logic [CW-1:0] exp_ms(logic r);
`ifdef PIPE_STALL_CNT_EN
    return r ? '0 : m_ms;
`else
    return r ? '0 : '0;
`endif
  endfunction

  // One cycle: drive after the edge, check at the falling edge, then advance the model.
  task automatic step(in_t v, string nm, bit use_exp, out_t exp);
    @(posedge clk);
    #1;
    rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
    ex_memread = v.memread; ex_rd = v.rd; branch_taken = v.br;
    mem_req = v.req; mem_ack = v.ack;
    @(negedge clk);
    chk({nm, "_model"}, 32'(dut_out()), 32'(model_out(v)));
    if (use_exp) chk(nm, 32'(dut_out()), 32'(exp));
    chk({nm, "_lucnt"}, 32'(lu_stall_cnt), 32'(exp_lu(v.rst)));
    chk({nm, "_mscnt"}, 32'(mem_stall_cnt), 32'(exp_ms(v.rst)));
    model_step(v);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    in_t  idle, v;
    logic [CW-1:0] ms_before;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = '{mk(0, 8, 3, 0, 1, 8, 0, 0, 0), O_LU};
    tbl[1]  = '{mk(0, 0, 0, 1, 1, 0, 0, 0, 0), O_NONE};
    tbl[2]  = '{mk(0, 2, 9, 1, 1, 9, 0, 0, 0), O_LU};
    tbl[3]  = '{mk(0, 2, 9, 0, 1, 9, 0, 0, 0), O_NONE};
    tbl[4]  = '{mk(0, 8, 8, 1, 0, 8, 0, 0, 0), O_NONE};
    tbl[5]  = '{mk(0, 1, 2, 1, 1, 5, 1, 0, 0), O_BR};
    tbl[6]  = '{mk(0, 8, 0, 0, 1, 8, 1, 0, 0), O_LU};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1), O_NONE};
    tbl[8]  = '{mk(0, 31, 4, 0, 1, 31, 0, 0, 0), O_LU};
    tbl[9]  = '{mk(0, 1, 2, 0, 0, 3, 1, 1, 1), O_BR};
    tbl[10] = '{mk(1, 8, 8, 1, 1, 8, 1, 1, 0), O_NONE};

    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 0; ex_memread = 0;
    ex_rd = '0; branch_taken = 0; mem_req = 0; mem_ack = 0;

    v = idle; v.rst = 1'b1;
    step(v, "reset0", 1, O_NONE);
    step(v, "reset1", 1, O_NONE);

    for (int i = 0; i < 11; i++) step(tbl[i].in, $sformatf("tbl%0d", i), 1, tbl[i].exp);
    step(idle, "idle", 1, O_NONE);

    // Memory wait with ack on the fourth cycle.
    ms_before = mem_stall_cnt;
    v = idle; v.req = 1;
    step(v, "wait0", 1, O_MS);
    step(v, "wait1", 1, O_MS | O_BUSY);
    step(v, "wait2", 1, O_MS | O_BUSY);
    v.ack = 1;
    step(v, "wait_ack", 1, O_BUSY);
    step(idle, "wait_done", 1, O_NONE);
`ifdef PIPE_STALL_CNT_EN
    chk("wait_mscnt_delta", 32'(mem_stall_cnt - ms_before), 32'd3);
`else
    chk("wait_mscnt_delta", 32'(mem_stall_cnt - ms_before), 32'd0);
`endif

    // Zero-wait access.
    v = idle; v.req = 1; v.ack = 1;
    step(v, "zw", 1, O_NONE);
    step(idle, "zw_after", 1, O_NONE);

    // Priority: memory stall hides load-use and branch; ack cycle exposes load-use.
    v = mk(0, 8, 0, 0, 1, 8, 1, 1, 0);
    step(v, "prio_ms", 1, O_MS);
    v.ack = 1;
    step(v, "prio_ack", 1, O_LU | O_BUSY);
    step(idle, "prio_done", 1, O_NONE);

    // Timeout after MEM_TIMEOUT stalled cycles; late ack ignored; rst clears.
    v = idle; v.req = 1;
    step(v, "to0", 1, O_MS);
    step(v, "to1", 1, O_MS | O_BUSY);
    step(v, "to2", 1, O_MS | O_BUSY);
    step(v, "to3", 1, O_MS | O_BUSY);
    step(v, "to_err", 1, O_MS | O_TO);
    v.ack = 1;
    step(v, "to_lateack", 1, O_MS | O_TO);
    step(idle, "to_idle", 1, O_MS | O_TO);
    v = idle; v.rst = 1;
    step(v, "to_rst", 1, O_NONE);
    step(idle, "to_clear", 1, O_NONE);

    // Reset in the middle of a wait.
    v = idle; v.req = 1;
    step(v, "rw0", 1, O_MS);
    step(v, "rw1", 1, O_MS | O_BUSY);
    v.rst = 1;
    step(v, "rw_rst", 1, O_NONE);
    step(idle, "rw_after", 1, O_NONE);

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      v.rst     = ($urandom_range(99) == 0);
      v.rs      = 5'($urandom_range(3));
      v.rt      = 5'($urandom_range(3));
      v.rd      = 5'($urandom_range(3));
      v.uses_rt = 1'($urandom);
      v.memread = 1'($urandom);
      v.br      = ($urandom_range(3) == 0);
      v.req     = ($urandom_range(9) < 3);
      v.ack     = ($urandom_range(9) < 4);
      step(v, "rand", 0, O_NONE);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
